z80fi_ir_tracker: RTL and testbench
===================================

Name: z80fi_ir_tracker

Overview:
- Sequential reference model of the Z80 I and R registers, driven by the z80fi retirement stream.
- Keeps shadow I/R across instructions and checks every retired instruction's I/R in/out values against the shadow.
- Generalises the single-instruction LD I,A spec: covers LD I,A, LD R,A, LD A,I and LD A,R, plus R refresh increments on every retirement.
- Sits beside the per-instruction spec modules in the formal harness; outputs feed assertions.

Parameters:
- COUNT_W, 16, width of the retire and error counters (saturating).
- CHECK_R, 1, 1 = check R values and R-based A loads; 0 = track I only, R errors suppressed.
- CHECK_A, 1, 1 = check A output of LD A,I / LD A,R.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- z80fi_valid  in  1  retirement strobe, one instruction per high cycle
- z80fi_insn  in  32  instruction bytes, first byte in [7:0]
- z80fi_insn_len  in  3  instruction length in bytes
- z80fi_reg_a_in / z80fi_reg_a_out  in  8 each  A before/after
- z80fi_reg_i_in / z80fi_reg_i_out  in  8 each  I before/after
- z80fi_reg_r_in / z80fi_reg_r_out  in  8 each  R before/after
- synced  out  1  shadow initialised
- err  out  1  sticky error flag
- err_code  out  3  first error cause: 0 none, 1 I_IN, 2 R_IN, 3 I_OUT, 4 R_OUT, 5 A_OUT
- err_count  out  COUNT_W  number of erroneous retirements
- retire_count  out  COUNT_W  number of retirements seen

Behaviour:
- Reset (sync, clk edge with reset=1): synced=0, err=0, err_code=0, counters=0, shadow_i=0, shadow_r=0. Reset mid-stream discards the shadow; the next valid re-syncs.
- Decode, all combinational on z80fi_insn:
  - LDIA = ED 47, LDRA = ED 4F, LDAI = ED 57, LDAR = ED 5F; each requires insn_len==2.
  - m1 = 2 if byte0 is CB, DD, ED or FD; otherwise m1 = 1.
- Expected values:
  - r_inc = {r_base[7], r_base[6:0] + m1}, 7-bit wrap, bit 7 preserved. r_base is the shadow R, or z80fi_reg_r_in on the sync cycle.
  - exp_i = A_in if LDIA, else i_base.
  - exp_r = A_in if LDRA, else r_inc.
  - exp_a for LDAI = i_base; for LDAR = r_inc (value after both M1 increments).
- Sync cycle (valid && !synced):
  - Adopt the I_in/R_in inputs as the base; skip the in-checks; apply the out-checks.
  - Set synced=1 and shadow <= {exp_i, exp_r}.
- Synced cycle (valid && synced):
  - In-checks: I_in==shadow_i, R_in==shadow_r.
  - Out-checks: I_out==exp_i, R_out==exp_r, plus the A_out check for LDAI/LDAR.
  - Update shadow <= {exp_i, exp_r}. The shadow follows the model, not the DUT, so an error does not propagate.
- Checks gated by parameters: with CHECK_R=0, R_IN, R_OUT and the LDAR A check never fire; with CHECK_A=0, A_OUT never fires.
- Error reporting:
  - Any failing check sets err on the next edge.
  - err_code latches only while err_code==0, choosing the lowest-numbered failing cause.
  - err_count increments by 1 per erroneous retirement, not per failing check.
- Counters: retire_count increments on every valid; both counters saturate at all-ones.
- Latency: outputs are registered, one cycle after the valid cycle. Back-to-back valids are fully supported with no bubbles.
- valid=0: state holds.
- Simultaneous reset and valid: reset wins; the instruction is ignored.

Decomposition:
- Shared package z80fi_ir_pkg:
  - opcode constants for the four ED-page loads and the prefix bytes CB/DD/ED/FD;
  - err_code enum (3 bits);
  - function r_refresh(r, m1).
- One sub-module, z80fi_ir_decode: combinational insn/len -> {is_ldia, is_ldra, is_ldai, is_ldar, m1}. It is reusable by the other spec modules.
- Shadow, check and counter logic stays in the top module.

Test Plan:
- Reset, then NOP (00) with I_in=12, R_in=7F, I_out=12, R_out=00 -> synced=1, err=0, shadow_r=00 (7-bit wrap, bit7 kept 0).
- Synced at R=85, instruction ED 47 with A_in=3C, I_out=3C, R_out=87 -> no error; shadow_i=3C, shadow_r=87.
- Synced at R=10, instruction ED 4F with A_in=9A, R_out=9A, then NOP with R_in=9A, R_out=9B -> no error.
- Synced at I=55, R=20, instruction ED 5F with A_out=22, then ED 57 with A_out=55 -> no error. Repeat with A_out=21 -> err=1, err_code=5, err_count=1.
- Synced at I=3C, next valid with I_in=3D -> err_code=1. A later R_OUT mismatch keeps err_code=1 and raises err_count to 2.
- Reset asserted mid-stream, in the same cycle as a valid -> all outputs zero next cycle, synced=0; the following valid re-syncs with no error. Run again with CHECK_R=0 and a bad R_out -> err stays 0.

Source files
------------

// File: rtl/z80fi_ir_pkg.sv
// Shared opcodes, error causes and the R refresh rule for the z80fi I/R reference models.
package z80fi_ir_pkg;

    localparam logic [7:0] OP_PFX_CB = 8'hCB;
    localparam logic [7:0] OP_PFX_DD = 8'hDD;
    localparam logic [7:0] OP_PFX_ED = 8'hED;
    localparam logic [7:0] OP_PFX_FD = 8'hFD;

    // Second byte of the ED-page loads between A and I/R.
    localparam logic [7:0] OP_LDIA = 8'h47;
    localparam logic [7:0] OP_LDRA = 8'h4F;
    localparam logic [7:0] OP_LDAI = 8'h57;
    localparam logic [7:0] OP_LDAR = 8'h5F;

    typedef enum logic [2:0] {
        ERR_NONE  = 3'd0,
        ERR_I_IN  = 3'd1,
        ERR_R_IN  = 3'd2,
        ERR_I_OUT = 3'd3,
        ERR_R_OUT = 3'd4,
        ERR_A_OUT = 3'd5
    } err_code_e;

    // Refresh counts only in the low 7 bits; bit 7 is whatever software last loaded.
    function automatic logic [7:0] r_refresh(input logic [7:0] r, input logic [1:0] m1);
        logic [6:0] low;
        low = r[6:0] + {5'd0, m1};
        return {r[7], low};
    endfunction

endpackage

// File: rtl/z80fi_ir_decode.sv
// Combinational decode of the four A<->I/R loads and the number of M1 cycles of a retired instruction.
module z80fi_ir_decode
    import z80fi_ir_pkg::*;
(
    input  logic [15:0] insn_i,
    input  logic [2:0]  insn_len_i,
    output logic        is_ldia_o,
    output logic        is_ldra_o,
    output logic        is_ldai_o,
    output logic        is_ldar_o,
    output logic [1:0]  m1_o
);

    logic [7:0] byte0;
    logic [7:0] byte1;
    logic       ed_pair;

    always_comb begin
        byte0     = insn_i[7:0];
        byte1     = insn_i[15:8];
        ed_pair   = (insn_len_i == 3'd2) && (byte0 == OP_PFX_ED);
        is_ldia_o = ed_pair && (byte1 == OP_LDIA);
        is_ldra_o = ed_pair && (byte1 == OP_LDRA);
        is_ldai_o = ed_pair && (byte1 == OP_LDAI);
        is_ldar_o = ed_pair && (byte1 == OP_LDAR);
        m1_o      = ((byte0 == OP_PFX_CB) || (byte0 == OP_PFX_DD) ||
                     (byte0 == OP_PFX_ED) || (byte0 == OP_PFX_FD)) ? 2'd2 : 2'd1;
    end

endmodule

// File: rtl/z80fi_ir_tracker.sv
// Shadows Z80 I/R across the z80fi retirement stream and flags any retirement whose I/R/A values disagree.
// Outputs are registered one cycle after each valid; accepts a retirement every cycle.
module z80fi_ir_tracker
    import z80fi_ir_pkg::*;
#(
    parameter int COUNT_W = 16,
    parameter bit CHECK_R = 1'b1,
    parameter bit CHECK_A = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               z80fi_valid,
    input  logic [31:0]        z80fi_insn,
    input  logic [2:0]         z80fi_insn_len,
    input  logic [7:0]         z80fi_reg_a_in,
    input  logic [7:0]         z80fi_reg_a_out,
    input  logic [7:0]         z80fi_reg_i_in,
    input  logic [7:0]         z80fi_reg_i_out,
    input  logic [7:0]         z80fi_reg_r_in,
    input  logic [7:0]         z80fi_reg_r_out,
    output logic               synced,
    output logic               err,
    output logic [2:0]         err_code,
    output logic [COUNT_W-1:0] err_count,
    output logic [COUNT_W-1:0] retire_count
);

    logic               synced_q, synced_d;
    logic               err_q, err_d;
    err_code_e          err_code_q, err_code_d;
    logic [COUNT_W-1:0] err_count_q, err_count_d;
    logic [COUNT_W-1:0] retire_count_q, retire_count_d;
    logic [7:0]         shadow_i_q, shadow_i_d;
    logic [7:0]         shadow_r_q, shadow_r_d;

    logic       is_ldia, is_ldra, is_ldai, is_ldar;
    logic [1:0] m1;
    logic [7:0] i_base, r_base, r_inc, exp_i, exp_r;
    logic [4:0] fail;
    err_code_e  first_cause;

    // Only the first two instruction bytes matter for these opcodes.
    logic unused_insn_hi;
    assign unused_insn_hi = ^z80fi_insn[31:16];

    z80fi_ir_decode u_decode (
        .insn_i     (z80fi_insn[15:0]),
        .insn_len_i (z80fi_insn_len),
        .is_ldia_o  (is_ldia),
        .is_ldra_o  (is_ldra),
        .is_ldai_o  (is_ldai),
        .is_ldar_o  (is_ldar),
        .m1_o       (m1)
    );

    always_comb begin
        // On the sync retirement the DUT's own inputs become the reference.
        i_base = synced_q ? shadow_i_q : z80fi_reg_i_in;
        r_base = synced_q ? shadow_r_q : z80fi_reg_r_in;
        r_inc  = r_refresh(r_base, m1);
        exp_i  = is_ldia ? z80fi_reg_a_in : i_base;
        exp_r  = is_ldra ? z80fi_reg_a_in : r_inc;

        fail[0] = synced_q && (z80fi_reg_i_in != shadow_i_q);
        fail[1] = CHECK_R && synced_q && (z80fi_reg_r_in != shadow_r_q);
        fail[2] = (z80fi_reg_i_out != exp_i);
        fail[3] = CHECK_R && (z80fi_reg_r_out != exp_r);
        fail[4] = CHECK_A && ((is_ldai && (z80fi_reg_a_out != i_base)) ||
                              (CHECK_R && is_ldar && (z80fi_reg_a_out != r_inc)));

        if (fail[0])      first_cause = ERR_I_IN;
        else if (fail[1]) first_cause = ERR_R_IN;
        else if (fail[2]) first_cause = ERR_I_OUT;
        else if (fail[3]) first_cause = ERR_R_OUT;
        else if (fail[4]) first_cause = ERR_A_OUT;
        else              first_cause = ERR_NONE;
    end

    always_comb begin
        synced_d       = synced_q;
        err_d          = err_q;
        err_code_d     = err_code_q;
        err_count_d    = err_count_q;
        retire_count_d = retire_count_q;
        shadow_i_d     = shadow_i_q;
        shadow_r_d     = shadow_r_q;

        if (z80fi_valid) begin
            synced_d = 1'b1;
            // Shadow follows the model so one bad retirement is reported once, not forever.
            shadow_i_d = exp_i;
            shadow_r_d = exp_r;
            if (retire_count_q != '1) retire_count_d = retire_count_q + 1'b1;
            if (|fail) begin
                err_d = 1'b1;
                if (err_code_q == ERR_NONE) err_code_d = first_cause;
                if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            synced_q       <= 1'b0;
            err_q          <= 1'b0;
            err_code_q     <= ERR_NONE;
            err_count_q    <= '0;
            retire_count_q <= '0;
            shadow_i_q     <= 8'h00;
            shadow_r_q     <= 8'h00;
        end else begin
            synced_q       <= synced_d;
            err_q          <= err_d;
            err_code_q     <= err_code_d;
            err_count_q    <= err_count_d;
            retire_count_q <= retire_count_d;
            shadow_i_q     <= shadow_i_d;
            shadow_r_q     <= shadow_r_d;
        end
    end

    assign synced       = synced_q;
    assign err          = err_q;
    assign err_code     = err_code_q;
    assign err_count    = err_count_q;
    assign retire_count = retire_count_q;

endmodule

// File: tb/tb_z80fi_ir_tracker.sv
// Scoreboard bench: a full-checking tracker and an I-only tracker with 4-bit counters share one stimulus stream.
module tb_z80fi_ir_tracker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0;
    logic [31:0] insn = '0;
    logic [2:0]  len = '0;
    logic [7:0]  a_in = '0, a_out = '0, i_in = '0, i_out = '0, r_in = '0, r_out = '0;

    logic        sy0, er0, sy1, er1;
    logic [2:0]  code0, code1;
    logic [15:0] ecnt0, rcnt0;
    logic [3:0]  ecnt1, rcnt1;

    always #5 clk = ~clk;

    z80fi_ir_tracker #(.COUNT_W(16), .CHECK_R(1'b1), .CHECK_A(1'b1)) dut_full (
        .clk(clk), .reset(reset), .z80fi_valid(valid), .z80fi_insn(insn), .z80fi_insn_len(len),
        .z80fi_reg_a_in(a_in), .z80fi_reg_a_out(a_out), .z80fi_reg_i_in(i_in), .z80fi_reg_i_out(i_out),
        .z80fi_reg_r_in(r_in), .z80fi_reg_r_out(r_out),
        .synced(sy0), .err(er0), .err_code(code0), .err_count(ecnt0), .retire_count(rcnt0)
    );

    z80fi_ir_tracker #(.COUNT_W(4), .CHECK_R(1'b0), .CHECK_A(1'b1)) dut_ionly (
        .clk(clk), .reset(reset), .z80fi_valid(valid), .z80fi_insn(insn), .z80fi_insn_len(len),
        .z80fi_reg_a_in(a_in), .z80fi_reg_a_out(a_out), .z80fi_reg_i_in(i_in), .z80fi_reg_i_out(i_out),
        .z80fi_reg_r_in(r_in), .z80fi_reg_r_out(r_out),
        .synced(sy1), .err(er1), .err_code(code1), .err_count(ecnt1), .retire_count(rcnt1)
    );

    typedef struct {
        bit         sy;
        bit         er;
        logic [2:0] code;
        int         ecnt;
        int         rcnt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_vec = 0;
    int n_bad = 0;

    // Reference state: one shadow (identical for both trackers), per-tracker error bookkeeping.
    bit         m_sy;
    logic [7:0] m_i, m_r;
    bit         m_err[2];
    logic [2:0] m_code[2];
    int         m_ecnt[2], m_rcnt[2];
    int         cmax[2] = '{65535, 15};

    function automatic void ref_calc(input logic [15:0] op, input logic [2:0] ln, input logic [7:0] ai,
                                     input logic [7:0] ib, input logic [7:0] rb,
                                     output logic [7:0] ei, output logic [7:0] er, output logic [7:0] ea,
                                     output bit a_chk, output bit a_is_r);
        logic [7:0] b0, b1, rinc;
        int m1;
        bit two;
        b0 = op[7:0];
        b1 = op[15:8];
        m1 = (b0 == 8'hCB || b0 == 8'hDD || b0 == 8'hED || b0 == 8'hFD) ? 2 : 1;
        two = (ln == 3'd2) && (b0 == 8'hED);
        rinc = 8'((rb & 8'h80) | ((rb + m1) & 8'h7F));
        ei = (two && b1 == 8'h47) ? ai : ib;
        er = (two && b1 == 8'h4F) ? ai : rinc;
        a_chk = two && (b1 == 8'h57 || b1 == 8'h5F);
        a_is_r = two && (b1 == 8'h5F);
        ea = a_is_r ? rinc : ib;
    endfunction

    task automatic apply(input bit rst, input bit v, input logic [15:0] op, input logic [2:0] ln,
                         input logic [7:0] ai, input logic [7:0] ao, input logic [7:0] ii,
                         input logic [7:0] io, input logic [7:0] ri, input logic [7:0] ro);
        logic [31:0] hi;
        logic [7:0] ib, rb, ei, er, ea;
        bit a_chk, a_is_r, cr;
        int c;
        exp_t e;
        @(negedge clk);
        hi = $urandom();
        reset = rst; valid = v; insn = {hi[31:16], op}; len = ln;
        a_in = ai; a_out = ao; i_in = ii; i_out = io; r_in = ri; r_out = ro;
        if (rst) begin
            m_sy = 0; m_i = 8'h00; m_r = 8'h00;
            for (int k = 0; k < 2; k++) begin
                m_err[k] = 0; m_code[k] = 3'd0; m_ecnt[k] = 0; m_rcnt[k] = 0;
            end
        end else if (v) begin
            ib = m_sy ? m_i : ii;
            rb = m_sy ? m_r : ri;
            ref_calc(op, ln, ai, ib, rb, ei, er, ea, a_chk, a_is_r);
            for (int k = 0; k < 2; k++) begin
                cr = (k == 0);
                if (m_sy && ii != m_i) c = 1;
                else if (cr && m_sy && ri != m_r) c = 2;
                else if (io != ei) c = 3;
                else if (cr && ro != er) c = 4;
                else if (a_chk && (cr || !a_is_r) && ao != ea) c = 5;
                else c = 0;
                if (c != 0) begin
                    m_err[k] = 1;
                    if (m_code[k] == 3'd0) m_code[k] = 3'(c);
                    if (m_ecnt[k] < cmax[k]) m_ecnt[k]++;
                end
                if (m_rcnt[k] < cmax[k]) m_rcnt[k]++;
            end
            m_sy = 1; m_i = ei; m_r = er;
        end
        for (int k = 0; k < 2; k++) begin
            e.sy = m_sy; e.er = m_err[k]; e.code = m_code[k]; e.ecnt = m_ecnt[k]; e.rcnt = m_rcnt[k];
            if (k == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    // Consistent retirement built from the model's shadow; bad flips one field to provoke a check.
    task automatic good(input logic [15:0] op, input logic [2:0] ln, input logic [4:0] bad);
        logic [7:0] ai, ii, ri, ei, er, ea, ao, fl;
        bit a_chk, a_is_r;
        ai = 8'($urandom());
        ii = m_sy ? m_i : 8'($urandom());
        ri = m_sy ? m_r : 8'($urandom());
        ref_calc(op, ln, ai, ii, ri, ei, er, ea, a_chk, a_is_r);
        ao = a_chk ? ea : 8'($urandom());
        fl = 8'(1 << $urandom_range(0, 7));
        if (bad[0]) ii = ii ^ fl;
        if (bad[1]) ri = ri ^ fl;
        if (bad[2]) ei = ei ^ fl;
        if (bad[3]) er = er ^ fl;
        if (bad[4]) ao = ao ^ fl;
        apply(0, 1, op, ln, ai, ao, ii, ei, ri, er);
    endtask

    task automatic chk(input string nm, input logic [36:0] act, input exp_t e);
        logic [36:0] want;
        want = {e.sy, e.er, e.code, 16'(e.ecnt), 16'(e.rcnt)};
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s @%0t: got synced=%0d err=%0d code=%0d err_count=%0d retire_count=%0d, expected synced=%0d err=%0d code=%0d err_count=%0d retire_count=%0d",
                     nm, $time, act[36], act[35], act[34:32], act[31:16], act[15:0],
                     e.sy, e.er, e.code, e.ecnt, e.rcnt);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("full", {sy0, er0, code0, ecnt0, rcnt0}, e);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("ionly", {sy1, er1, code1, 12'd0, ecnt1, 12'd0, rcnt1}, e);
            end
        end
    end

    initial begin
        logic [15:0] op;
        logic [2:0]  ln;
        logic [4:0]  bad;
        int sel, waited;

        apply(1, 0, 16'h0000, 3'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        apply(1, 0, 16'h0000, 3'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        // Sync on NOP: R 7F wraps to 00 with bit 7 kept.
        apply(0, 1, 16'h0000, 3'd1, 8'h00, 8'h00, 8'h12, 8'h12, 8'h7F, 8'h00);
        apply(0, 1, 16'h0000, 3'd1, 8'h00, 8'h00, 8'h12, 8'h12, 8'h00, 8'h01);

        // LD I,A at R=85.
        apply(1, 0, 16'h0000, 3'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        apply(0, 1, 16'h0000, 3'd1, 8'h00, 8'h00, 8'h11, 8'h11, 8'h84, 8'h85);
        apply(0, 1, 16'h47ED, 3'd2, 8'h3C, 8'h00, 8'h11, 8'h3C, 8'h85, 8'h87);
        apply(0, 1, 16'h0000, 3'd1, 8'h00, 8'h00, 8'h3C, 8'h3C, 8'h87, 8'h88);

        // LD R,A at R=10, then NOP continuing from the loaded R.
        apply(1, 0, 16'h0000, 3'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        apply(0, 1, 16'h0000, 3'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h10);
        apply(0, 1, 16'h4FED, 3'd2, 8'h9A, 8'h00, 8'h00, 8'h00, 8'h10, 8'h9A);
        apply(0, 1, 16'h0000, 3'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h9A, 8'h9B);

        // LD A,R then LD A,I at I=55, R=20.
        apply(1, 0, 16'h0000, 3'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        apply(0, 1, 16'h0000, 3'd1, 8'h00, 8'h00, 8'h55, 8'h55, 8'h1F, 8'h20);
        apply(0, 1, 16'h5FED, 3'd2, 8'h00, 8'h22, 8'h55, 8'h55, 8'h20, 8'h22);
        apply(0, 1, 16'h57ED, 3'd2, 8'h00, 8'h55, 8'h55, 8'h55, 8'h22, 8'h24);
        // Same LD A,R with A off by one.
        apply(1, 0, 16'h0000, 3'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        apply(0, 1, 16'h0000, 3'd1, 8'h00, 8'h00, 8'h55, 8'h55, 8'h1F, 8'h20);
        apply(0, 1, 16'h5FED, 3'd2, 8'h00, 8'h21, 8'h55, 8'h55, 8'h20, 8'h22);

        // I_IN mismatch, then a later R_OUT mismatch keeps the first cause.
        apply(1, 0, 16'h0000, 3'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        apply(0, 1, 16'h0000, 3'd1, 8'h00, 8'h00, 8'h3C, 8'h3C, 8'h00, 8'h01);
        apply(0, 1, 16'h0000, 3'd1, 8'h00, 8'h00, 8'h3D, 8'h3C, 8'h01, 8'h02);
        apply(0, 1, 16'h0000, 3'd1, 8'h00, 8'h00, 8'h3C, 8'h3C, 8'h02, 8'h00);

        // Reset together with valid: instruction ignored, next valid re-syncs.
        apply(1, 1, 16'h47ED, 3'd2, 8'h77, 8'h00, 8'h01, 8'h77, 8'h02, 8'h04);
        good(16'h0000, 3'd1, 5'b00000);
        good(16'h00CB, 3'd2, 5'b00000);
        // Bad R_out alone: only the R-checking tracker reports it.
        good(16'h0000, 3'd1, 5'b01000);

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                apply(1, 1'($urandom_range(0, 1)), 16'h47ED, 3'd2, 8'h5A, 8'h00, 8'h00, 8'h5A, 8'h00, 8'h00);
            end else if ($urandom_range(0, 7) == 0) begin
                apply(0, 0, 16'($urandom()), 3'($urandom()), 8'($urandom()), 8'($urandom()),
                      8'($urandom()), 8'($urandom()), 8'($urandom()), 8'($urandom()));
            end else begin
                sel = $urandom_range(0, 9);
                op = 16'($urandom());
                ln = 3'd2;
                case (sel)
                    0: begin op[7:0] = 8'h00; ln = 3'd1; end
                    1: op = 16'h47ED;
                    2: op = 16'h4FED;
                    3: op = 16'h57ED;
                    4: op = 16'h5FED;
                    5: op[7:0] = 8'hCB;
                    6: begin op[7:0] = 8'hDD; ln = 3'($urandom_range(2, 4)); end
                    7: begin op[7:0] = 8'hFD; ln = 3'($urandom_range(2, 4)); end
                    8: begin op = (16'($urandom_range(0, 1)) ? 16'h47ED : 16'h5FED); ln = 3'd3; end
                    default: ln = 3'($urandom_range(1, 4));
                endcase
                bad = ($urandom_range(0, 7) == 0) ? 5'(1 << $urandom_range(0, 4)) : 5'd0;
                good(op, ln, bad);
            end
        end

        apply(0, 0, 16'h0000, 3'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        waited = 0;
        while ((q0.size() > 0 || q1.size() > 0) && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (q0.size() > 0 || q1.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d/%0d expected entries left unchecked, required 0", q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
